// File: rtl/addr_fetch.sv
// Fetches one 16-bit little-endian operand as two byte reads and writes it to the acu.
// Every output is a flop computed from the next state.
module addr_fetch #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  d,
  output logic        wl,
  output logic        wh,
  output logic        oe,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] ptr_next
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, REQ_LO, WR_LO, REQ_HI, WR_HI, DONE, ERR
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic                mem_req_q, mem_req_d;
  logic [DW-1:0]       d_q, d_d;
  logic                wl_q, wl_d;
  logic                wh_q, wh_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [AW-1:0]       ptr_next_q, ptr_next_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      wait_q     <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      d_q        <= '0;
      wl_q       <= 1'b0;
      wh_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ptr_next_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wait_q     <= wait_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      d_q        <= d_d;
      wl_q       <= wl_d;
      wh_q       <= wh_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ptr_next_q <= ptr_next_d;
    end
  end

  // Next state plus the values the output flops take on entering it.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wait_d     = wait_q;
    mem_addr_d = mem_addr_q;
    d_d        = d_q;
    oe_d       = oe_q;
    ptr_next_d = ptr_next_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = REQ_LO;
          ptr_d      = base;
          wait_d     = '0;
          mem_addr_d = base;
          oe_d       = 1'b0;
        end
      end
      REQ_LO, REQ_HI: begin
        if (mem_ack) begin
          state_d = (state_q == REQ_LO) ? WR_LO : WR_HI;
          d_d     = mem_data;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WR_LO: begin
        state_d    = REQ_HI;
        mem_addr_d = ptr_q + AW'(1);
      end
      WR_HI: begin
        state_d    = DONE;
        ptr_next_d = ptr_q + AW'(2);
        oe_d       = 1'b1;
      end
      DONE: state_d = IDLE;
      ERR: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    mem_req_d = (state_d == REQ_LO) || (state_d == REQ_HI);
    wl_d      = (state_d == WR_LO);
    wh_d      = (state_d == WR_HI);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;
  assign d        = d_q;
  assign wl       = wl_q;
  assign wh       = wh_q;
  assign oe       = oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ptr_next = ptr_next_q;

endmodule

// File: tb/tb_addr_fetch.sv
// Bench for addr_fetch: vector table of fetches plus a scoreboard of expected
// address/strobe/done events, checked by a monitor on the falling edge.
module tb_addr_fetch;

  localparam int unsigned TIMEOUT = 15;
  localparam int EV_ADDR = 0, EV_WL = 1, EV_WH = 2, EV_DONE = 3, EV_ERR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base = '0;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = '0;
  logic [7:0]  d;
  logic        wl, wh, oe, busy, done, err;
  logic [15:0] ptr_next;

  addr_fetch #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
    .d(d), .wl(wl), .wh(wh), .oe(oe), .busy(busy), .done(done), .err(err),
    .ptr_next(ptr_next)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          dlo;
    int          dhi;
    int          exp_cyc;
    bit          is_err;
  } vec_t;

  typedef struct {
    int          kind;
    logic [15:0] val;
    logic [15:0] val2;
  } ev_t;

  ev_t         sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] acu_q = '0;
  logic        req_prev = 1'b0;
  vec_t        tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] val, input logic [15:0] val2,
                           input string name);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        n_errors++;
        $display("FAIL %s: got event kind %0d expected kind %0d at %0t", name, kind, e.kind, $time);
      end else begin
        if (val !== e.val) begin
          n_errors++;
          $display("FAIL %s: got %0h expected %0h at %0t", name, val, e.val, $time);
        end
        if (kind == EV_DONE) check("acu_q", 32'(acu_q), 32'(e.val2));
      end
    end
  endtask

  // Downstream acu model assembled from the write strobes.
  always @(posedge clk) begin
    if (wl) acu_q[7:0]  <= d;
    if (wh) acu_q[15:8] <= d;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (wl && wh) check("wl_wh_exclusive", 32'({wl, wh}), 32'h0);
      if (mem_req && !req_prev) expect_ev(EV_ADDR, mem_addr, 16'h0, "mem_addr");
      if (wl)   expect_ev(EV_WL, {8'h0, d}, 16'h0, "wl_d");
      if (wh)   expect_ev(EV_WH, {8'h0, d}, 16'h0, "wh_d");
      if (done) expect_ev(EV_DONE, ptr_next, 16'h0, "ptr_next");
      if (err)  expect_ev(EV_ERR, 16'h0, 16'h0, "err");
    end
    req_prev = rst ? 1'b0 : mem_req;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_ptr_next"}, 32'(ptr_next), 32'h0);
    check({tag, "_ctl"}, 32'({d, mem_req, wl, wh, oe, busy, done, err}), 32'h0);
  endtask

  // One fetch; glitch_cyc>0 pulses start then and acks outside requests,
  // rst_cyc>0 asserts reset in that cycle and abandons the fetch.
  task automatic do_fetch(input vec_t v, input int glitch_cyc, input int rst_cyc);
    int cyc, nreq_lo, nreq_hi, end_cyc;
    bit phase_hi, finished;
    logic [15:0] b1, b2;
    b1 = v.base + 16'd1;
    b2 = v.base + 16'd2;
    sb.push_back('{EV_ADDR, v.base, 16'h0});
    if (v.is_err) begin
      sb.push_back('{EV_ERR, 16'h0, 16'h0});
    end else begin
      sb.push_back('{EV_WL, {8'h0, v.lo}, 16'h0});
      sb.push_back('{EV_ADDR, b1, 16'h0});
      sb.push_back('{EV_WH, {8'h0, v.hi}, 16'h0});
      sb.push_back('{EV_DONE, b2, {v.hi, v.lo}});
    end
    nreq_lo = 0; nreq_hi = 0; phase_hi = 0; finished = 0; end_cyc = 0;
    @(negedge clk);
    base = v.base; start = 1'b1; cyc = 1;
    while (!finished && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (cyc == glitch_cyc);
      if (start) base = 16'hDEAD;
      mem_ack = 1'b0;
      mem_data = 8'($urandom);
      if (mem_req) begin
        if (!phase_hi) begin
          nreq_lo++;
          if (nreq_lo == v.dlo + 1) begin mem_ack = 1'b1; mem_data = v.lo; end
        end else begin
          nreq_hi++;
          if (nreq_hi == v.dhi + 1) begin mem_ack = 1'b1; mem_data = v.hi; end
        end
      end else if (glitch_cyc > 0) begin
        mem_ack = 1'b1;
      end
      if (wl) phase_hi = 1;
      if (cyc == rst_cyc) begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        finished = 1;
      end else if (done || err) begin
        finished = 1;
        end_cyc = cyc;
        if (err) check("err_mem_req", 32'(mem_req), 32'h0);
      end
    end
    mem_ack = 1'b0;
    start = 1'b0;
    if (rst_cyc > 0) begin
      sb.delete();
      repeat (2) @(negedge clk);
      check_reset_outputs("rst_hold");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_reset_outputs("rst_after");
    end else begin
      check("end_cycle", 32'(end_cyc), 32'(v.exp_cyc));
      if (v.is_err) begin
        check("req_cycles_timeout", 32'(nreq_lo), 32'(TIMEOUT));
      end else begin
        check("req_cycles_lo", 32'(nreq_lo), 32'(v.dlo + 1));
        check("req_cycles_hi", 32'(nreq_hi), 32'(v.dhi + 1));
      end
      @(negedge clk);
      check("idle_busy", 32'({busy, done, err}), 32'h0);
      check("idle_oe", 32'(oe), v.is_err ? 32'h0 : 32'h1);
      if (!v.is_err) check("idle_ptr_next", 32'(ptr_next), 32'(b2));
    end
    check("sb_empty", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    tbl[0] = '{16'h1234, 8'h64, 8'h40, 0, 0, 6, 1'b0};
    tbl[1] = '{16'hFFFF, 8'hAA, 8'h55, 0, 0, 6, 1'b0};
    tbl[2] = '{16'h8000, 8'h01, 8'hFE, 5, 5, 16, 1'b0};
    tbl[3] = '{16'h00FE, 8'h12, 8'h34, 2, 0, 8, 1'b0};
    tbl[4] = '{16'h7FFF, 8'h00, 8'hFF, 14, 14, 34, 1'b0};
    tbl[5] = '{16'h2000, 8'h00, 8'h00, 1000, 0, 17, 1'b1};

    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("por_release");

    for (int i = 0; i < 6; i++) do_fetch(tbl[i], 0, 0);

    do_fetch('{16'h4321, 8'h9C, 8'h3E, 0, 1, 7, 1'b0}, 4, 0);
    do_fetch('{16'h5555, 8'h11, 8'h22, 0, 0, 6, 1'b0}, 0, 3);
    do_fetch(tbl[0], 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addr_fetch.md
ADDR_FETCH -- requirements
Module: addr_fetch

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum wait cycles for mem_ack per byte (1..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request fetch of one 16-bit little-endian operand; sampled in IDLE only.
REQ-005 base  input  16  memory address of operand low byte; latched on accepted start.
REQ-006 mem_addr  output  16  byte address presented to memory.
REQ-007 mem_req  output  1  memory read request; held until acknowledged or timed out.
REQ-008 mem_ack  input  1  memory read acknowledge; mem_data valid in same cycle.
REQ-009 mem_data  input  8  memory read data.
REQ-010 d  output  8  byte to downstream acu.
REQ-011 wl  output  1  acu low-byte write strobe.
REQ-012 wh  output  1  acu high-byte write strobe.
REQ-013 oe  output  1  acu output enable.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 err  output  1  one-cycle pulse on ack timeout.
REQ-017 ptr_next  output  16  base+2 modulo 2^16, valid from the done pulse until next accepted start.

Function
REQ-018 All outputs SHALL be registered; states: IDLE, REQ_LO, WR_LO, REQ_HI, WR_HI, DONE, ERR.
REQ-019 IDLE: start=1 SHALL latch base into ptr, clear wait counter, and enter REQ_LO; mem_req=1 and mem_addr=ptr in the following cycle.
REQ-020 REQ_LO: mem_req SHALL stay high with mem_addr=ptr; on mem_ack=1 capture mem_data, go to WR_LO.
REQ-021 WR_LO: mem_req=0, d=captured byte, wl=1 for exactly one cycle; then REQ_HI.
REQ-022 REQ_HI: as REQ_LO with mem_addr=ptr+1 modulo 2^16 (0xFFFF wraps to 0x0000); on ack go to WR_HI.
REQ-023 WR_HI: d=captured byte, wh=1 for exactly one cycle; then DONE.
REQ-024 DONE: done=1, oe=1, ptr_next=ptr+2 modulo 2^16 for one cycle; then IDLE.
REQ-025 oe SHALL remain high in IDLE after a successful fetch until the next accepted start, and SHALL be 0 after err or reset.
REQ-026 Wait counter SHALL count cycles in REQ_LO/REQ_HI with mem_ack=0; reaching TIMEOUT SHALL enter ERR, drop mem_req.
REQ-027 ERR: err=1 one cycle, no wl/wh issued for the aborted byte; then IDLE.
REQ-028 wl and wh SHALL never be high together; neither SHALL be high outside WR_LO/WR_HI.
REQ-029 start while busy SHALL be ignored; mem_ack outside REQ_LO/REQ_HI SHALL be ignored.
REQ-030 Minimum latency with ack in first request cycle: start to done = 6 cycles.
REQ-031 d SHALL hold its last written value outside write states.

Reset
REQ-032 rst=1 SHALL immediately force IDLE and zero mem_addr, mem_req, d, wl, wh, oe, busy, done, err, ptr_next, ptr, wait counter.
REQ-033 Reset asserted mid-fetch SHALL abort without any further strobe; first start after release SHALL behave as from power-up.

Verification
REQ-034 base=0x1234, start; ack immediate with 0x64 then 0x40 -> mem_addr 0x1234 then 0x1235, wl with d=0x64, wh with d=0x40, done at cycle 6, ptr_next=0x1236, acu q=0x4064.
REQ-035 base=0xFFFF -> high-byte mem_addr=0x0000, ptr_next=0x0001.
REQ-036 mem_ack delayed 5 cycles per byte -> mem_req held 6 cycles each, done at cycle 16, data correct.
REQ-037 No ack, TIMEOUT=15 -> err pulse after 15 wait cycles in REQ_LO, no wl/wh, busy low next cycle, oe=0.
REQ-038 start pulsed during REQ_HI, and rst asserted in WR_LO of a second fetch -> first fetch unaffected; after reset, all outputs 0 with no wl strobe.
